ex: RTL and testbench
=====================

# ex

Execute stage of the ToruMIPS five-stage pipeline, fed directly by the `id_ex` pipeline register. It computes logic, shift and add/sub/compare results in the same cycle and drives them toward `ex_mem`. DIV/DIVU run on an iterative 32-cycle divider that holds the front of the pipeline through `stallreq_o`. Quotient and remainder leave on a HI/LO write port.

## Interface
Parameters: none. Widths and opcodes come from the `defines.v` macros: `AluOpBus` is 8 bits, `AluSelBus` 3, `RegBus` 32, `RegAddrBus` 5.
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  one clock; reset is asynchronous and active-high (`RstEnable` = 1)
- aluOp_i  in  8  operation, driven from `id_ex` ex_aluOp
- aluSel_i  in  3  result group: `EXE_RES_NOP`, `EXE_RES_LOGIC`, `EXE_RES_SHIFT`, `EXE_RES_ARITHMETIC`
- reg1_i  in  32  operand 1; for shifts, `[4:0]` is the shift amount
- reg2_i  in  32  operand 2; for shifts, the shifted value
- wd_i  in  5  destination register
- wreg_i  in  1  destination write enable
- flush_i  in  1  kill the current instruction and abort any divide
- wd_o  out  5  equals wd_i
- wreg_o  out  1  GPR write enable
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- stallreq_o  out  1  asks control to freeze PC, `if_id` and `id_ex`

## Operation
- Result groups (combinational):
  - LOGIC: OR, AND, XOR, NOR.
  - SHIFT: SLL, SRL, SRA of reg2_i by reg1_i[4:0].
  - ARITHMETIC: ADD, ADDU, SUB, SUBU, SLT (signed), SLTU (unsigned).
  - wdata_o is the selected group's result; `EXE_RES_NOP` gives 0.
- GPR write enable:
  - wreg_o = wreg_i, except ADD/SUB with signed overflow forces wreg_o = 0.
  - ADDU/SUBU never suppress the write.
  - flush_i = 1 forces wreg_o = 0.
- Divider FSM states: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- FREE: a DIV/DIVU op present with flush_i = 0 goes to
  - BY_ZERO if reg2_i = 0;
  - otherwise ON, latching the operand magnitudes (absolute values for DIV, raw for DIVU) and clearing the 6-bit counter.
- ON: one restoring-division bit per cycle and cnt++. After the 32nd iteration (cnt = 32) go to END.
- BY_ZERO: go to END with quotient = remainder = 0.
- END:
  - Apply sign correction for DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - whilo_o = 1, lo_o = quotient, hi_o = remainder.
  - Return to FREE on the next edge.
- stallreq_o = divide op present AND state ≠ END AND flush_i = 0.
- whilo_o is 1 only in END with flush_i = 0. hi_o/lo_o are 0 otherwise.
- flush_i = 1 in any state: next state FREE, partial result discarded.
- Divide ops leave wreg_o = 0 regardless of wreg_i.

## Timing
- Non-divide ops: zero-latency combinational path from `id_ex` outputs to `ex_mem` inputs.
- DIV/DIVU, nonzero divisor (FREE/ON/END on cycle 0/1..32/33):
  - cycle 0 FREE, stall high;
  - cycles 1–32 ON, stall high;
  - cycle 33 END, stall low, whilo_o = 1.
  - Result is captured by `ex_mem` at the end of cycle 33: 34 cycles total, 33 stalled.
- Divide by zero: cycle 0 FREE, cycle 1 BY_ZERO, cycle 2 END with hi = lo = 0.
- Back-to-back divides: the second starts in the FREE cycle immediately after END.
- rst asserted at any time, including mid-divide:
  - state FREE, counter and datapath registers 0;
  - all outputs forced to 0 while rst is high.
- Inputs must stay stable while stallreq_o is high; the stall control freezing `id_ex` guarantees this.

## Configuration
- `TORU_DIV_EN` defined: divider FSM and HI/LO port are built as described.
- `TORU_DIV_EN` undefined:
  - no FSM or divider registers;
  - DIV/DIVU behave as NOP (wreg_o = 0);
  - stallreq_o, whilo_o, hi_o, lo_o are tied to 0.

## Test plan
- OR 0x0F0F0000 | 0x000000FF with wreg_i = 1, wd = 3 -> same cycle wdata_o = 0x0F0F00FF, wreg_o = 1, wd_o = 3, stallreq_o = 0.
- ADD 0x7FFFFFFF + 1 -> wreg_o = 0. ADDU on the same operands -> wdata_o = 0x80000000, wreg_o = 1. SLT -1 < 1 -> 1; SLTU on the same operands -> 0.
- DIVU 100 / 7 -> stallreq_o high for 33 cycles, then one cycle with whilo_o = 1, lo_o = 14, hi_o = 2.
- DIV -7 / 2 -> lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo_o = 0x80000000, hi_o = 0.
- DIV 5 / 0 -> stall for 2 cycles, then whilo_o = 1 with hi_o = lo_o = 0.
- Abort checks:
  - flush_i pulsed at ON cycle 10 -> stallreq_o drops that cycle, whilo_o never asserts, FSM back in FREE.
  - rst pulsed mid-divide -> all outputs 0 immediately; a following DIVU 9/3 gives lo = 3, hi = 0 with full latency.

Source files
------------

// File: rtl/ex.sv
// ToruMIPS execute stage: single-cycle logic/shift/arith, iterative 32-step DIV/DIVU with HI/LO port.
// Define TORU_DIV_EN to build the divider; otherwise DIV/DIVU act as NOPs and stall/HI/LO are tied low.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluOp_i,
  input  logic [2:0]  aluSel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  logic        is_div;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] arith_res;
  logic [31:0] sum_res;
  logic [31:0] diff_res;
  logic        ov_add;
  logic        ov_sub;
  logic        ov_block;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] result;

  assign is_div = (aluOp_i == EXE_DIV_OP) || (aluOp_i == EXE_DIVU_OP);

  always_comb begin
    logic_res = '0;
    case (aluOp_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluOp_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = '0;
    endcase
  end

  // Overflow is computed separately for add and sub so that subtracting 0x80000000 is caught.
  assign sum_res  = reg1_i + reg2_i;
  assign diff_res = reg1_i - reg2_i;
  assign ov_add   = (reg1_i[31] == reg2_i[31]) && (sum_res[31] != reg1_i[31]);
  assign ov_sub   = (reg1_i[31] != reg2_i[31]) && (diff_res[31] != reg1_i[31]);
  assign slt_res  = $signed(reg1_i) < $signed(reg2_i);
  assign sltu_res = reg1_i < reg2_i;

  always_comb begin
    arith_res = '0;
    ov_block  = 1'b0;
    case (aluOp_i)
      EXE_ADD_OP:  begin arith_res = sum_res;  ov_block = ov_add; end
      EXE_ADDU_OP: arith_res = sum_res;
      EXE_SUB_OP:  begin arith_res = diff_res; ov_block = ov_sub; end
      EXE_SUBU_OP: arith_res = diff_res;
      EXE_SLT_OP:  arith_res = {31'd0, slt_res};
      EXE_SLTU_OP: arith_res = {31'd0, sltu_res};
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (aluSel_i)
      EXE_RES_LOGIC:      result = logic_res;
      EXE_RES_SHIFT:      result = shift_res;
      EXE_RES_ARITHMETIC: result = arith_res;
      EXE_RES_NOP:        result = '0;
      default:            result = '0;
    endcase
  end

  logic        div_whilo;
  logic        div_stall;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

`ifdef TORU_DIV_EN
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_signed;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE:    if (is_div && !flush_i) state_d = (reg2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON:      if (cnt_q == 6'd31) state_d = DIV_END;
      DIV_END:     state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
    if (flush_i) state_d = DIV_FREE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign div_signed = (aluOp_i == EXE_DIV_OP);
  // quo_q starts as the dividend and fills with quotient bits from the bottom as it shifts out.
  assign shifted    = {rem_q, quo_q[31]};
  assign trial      = shifted - {1'b0, dvsr_q};

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      DIV_FREE: begin
        if (is_div && !flush_i) begin
          cnt_d = '0;
          rem_d = '0;
          if (reg2_i == '0) begin
            quo_d     = '0;
            dvsr_d    = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            quo_d     = (div_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
            dvsr_d    = (div_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
            neg_quo_d = div_signed && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d = div_signed && reg1_i[31];
          end
        end
      end
      DIV_ON: begin
        cnt_d = cnt_q + 6'd1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    div_stall = is_div && (state_q != DIV_END) && !flush_i;
    div_whilo = (state_q == DIV_END) && !flush_i;
    div_lo    = '0;
    div_hi    = '0;
    if (div_whilo) begin
      div_lo = neg_quo_q ? (32'd0 - quo_q) : quo_q;
      div_hi = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign div_stall  = 1'b0;
  assign div_whilo  = 1'b0;
  assign div_hi     = '0;
  assign div_lo     = '0;
`endif

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i && !ov_block && !is_div && !flush_i;
    wdata_o    = result;
    whilo_o    = div_whilo;
    hi_o       = div_hi;
    lo_o       = div_lo;
    stallreq_o = div_stall;
    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the ToruMIPS execute stage; divider checks follow the TORU_DIV_EN build option.
module tb_ex;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [2:0] S_NOP   = 3'b000;
  localparam logic [2:0] S_LOG   = 3'b001;
  localparam logic [2:0] S_SHF   = 3'b010;
  localparam logic [2:0] S_ARI   = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluOp_i = '0;
  logic [2:0]  aluSel_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  ex dut (
    .clk(clk), .rst(rst), .aluOp_i(aluOp_i), .aluSel_i(aluSel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic wr, input logic [4:0] wd);
    @(negedge clk);
    aluOp_i = op; aluSel_i = sel; reg1_i = a; reg2_i = b; wreg_i = wr; wd_i = wd;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(OP_OR, S_LOG, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 5'd3);
    checks++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b, all required 0",
               wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_logic_shift;
    logic [7:0]  ops [8] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_SLL};
    logic [2:0]  sels[8] = '{S_LOG, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF, S_SHF};
    logic [31:0] as [8] = '{32'h0F0F_0000, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0F0F_0000,
                            32'd31, 32'd4, 32'd4, 32'h0000_0024};
    logic [31:0] bs [8] = '{32'h0000_00FF, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0000_00FF,
                            32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1};
    logic [31:0] exp[8] = '{32'h0F0F_00FF, 32'h0F00_0F00, 32'hF0F0_F0F0, 32'hF0F0_FF00,
                            32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h0000_0010};
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], sels[i], as[i], bs[i], 1'b1, 5'd3);
      checks++;
      if (wdata_o !== exp[i] || wreg_o !== 1'b1 || wd_o !== 5'd3 || stallreq_o !== 1'b0) begin
        errors++;
        $display("FAIL logic_shift[%0d]: wdata=%h wreg=%b wd=%0d stall=%b, required %h 1 3 0",
                 i, wdata_o, wreg_o, wd_o, stallreq_o, exp[i]);
      end
    end
    drive(OP_OR, S_NOP, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd7);
    checks++;
    if (wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL sel_nop: wdata=%h, required 0", wdata_o);
    end
  endtask

  task automatic test_arith;
    logic [7:0]  ops [9] = '{OP_ADD, OP_ADDU, OP_ADD, OP_SUB, OP_SUBU, OP_SUB, OP_SLT, OP_SLTU, OP_SUB};
    logic [31:0] as [9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000,
                            32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10};
    logic [31:0] bs [9] = '{32'h1, 32'h1, 32'd3, 32'h1, 32'h1, 32'h8000_0000, 32'h1, 32'h1, 32'd3};
    logic        ew [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ed [9] = '{32'h0, 32'h8000_0000, 32'd8, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h0, 32'd7};
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], S_ARI, as[i], bs[i], 1'b1, 5'd9);
      checks++;
      if (wreg_o !== ew[i] || (ew[i] && wdata_o !== ed[i])) begin
        errors++;
        $display("FAIL arith[%0d]: wreg=%b wdata=%h, required wreg=%b wdata=%h",
                 i, wreg_o, wdata_o, ew[i], ed[i]);
      end
    end
    drive(OP_ADDU, S_ARI, 32'd1, 32'd2, 1'b0, 5'd9);
    checks++;
    if (wreg_o !== 1'b0 || wdata_o !== 32'd3) begin
      errors++;
      $display("FAIL wreg_passthru: wreg=%b wdata=%h, required 0 00000003", wreg_o, wdata_o);
    end
    drive(OP_OR, S_LOG, 32'h1, 32'h2, 1'b1, 5'd4);
    flush_i = 1'b1;
    #1;
    checks++;
    if (wreg_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wreg: wreg=%b, required 0", wreg_o);
    end
    flush_i = 1'b0;
  endtask

`ifdef TORU_DIV_EN
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input int estall, input string nm);
    int n = 0;
    drive(op, S_NOP, a, b, 1'b1, 5'd2);
    while (stallreq_o === 1'b1 && n < 60) begin
      if (whilo_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_whilo: whilo=%b at stall cycle %0d, required 0", nm, whilo_o, n);
      end
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n !== estall) begin
      errors++;
      $display("FAIL %s_stall_cycles: %0d, required %0d", nm, n, estall);
    end
    checks++;
    if (whilo_o !== 1'b1 || lo_o !== elo || hi_o !== ehi || wreg_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: whilo=%b lo=%h hi=%h wreg=%b, required 1 %h %h 0",
               nm, whilo_o, lo_o, hi_o, wreg_o, elo, ehi);
    end
  endtask

  task automatic test_divide;
    run_div(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, "div_min_m1");
    run_div(OP_DIV, 32'd5, 32'd0, 32'h0, 32'h0, 2, "div_by_zero");
    drive(OP_NOP, S_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    checks++;
    if (whilo_o !== 1'b0 || stallreq_o !== 1'b0 || lo_o !== 32'h0 || hi_o !== 32'h0) begin
      errors++;
      $display("FAIL div_idle: whilo=%b stall=%b lo=%h hi=%h, required all 0", whilo_o, stallreq_o, lo_o, hi_o);
    end
  endtask

  task automatic test_flush;
    drive(OP_DIVU, S_NOP, 32'd100, 32'd7, 1'b0, 5'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b whilo=%b, required 0 0", stallreq_o, whilo_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    aluOp_i = OP_NOP;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (whilo_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_whilo: whilo=%b after flush, required 0", whilo_o);
      end
      @(negedge clk);
    end
    checks++;
    run_div(OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33, "after_flush");
  endtask

  task automatic test_rst_mid;
    drive(OP_DIVU, S_NOP, 32'd100, 32'd7, 1'b1, 5'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid: wd=%0d wreg=%b whilo=%b hi=%h lo=%h stall=%b, required all 0",
               wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    aluOp_i = OP_NOP;
    run_div(OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33, "after_rst");
  endtask
`else
  task automatic test_divide;
    drive(OP_DIVU, S_NOP, 32'd100, 32'd7, 1'b1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 ||
          wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
        errors++;
        $display("FAIL div_disabled[%0d]: stall=%b whilo=%b hi=%h lo=%h wreg=%b wdata=%h, required all 0",
                 i, stallreq_o, whilo_o, hi_o, lo_o, wreg_o, wdata_o);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_flush;
    drive(OP_DIV, S_NOP, 32'd5, 32'd0, 1'b1, 5'd2);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || wreg_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_disabled: stall=%b wreg=%b, required 0 0", stallreq_o, wreg_o);
    end
    flush_i = 1'b0;
  endtask

  task automatic test_rst_mid;
    drive(OP_ADDU, S_ARI, 32'd1, 32'd1, 1'b1, 5'd5);
    rst = 1'b1;
    #1;
    checks++;
    if (wreg_o !== 1'b0 || wdata_o !== 32'h0 || wd_o !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: wreg=%b wdata=%h wd=%0d, required 0", wreg_o, wdata_o, wd_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_logic_shift;
    test_arith;
    test_divide;
    test_flush;
    test_rst_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
